// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer: FSM encoding and default width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder; the single arithmetic cell the sequencer time-shares.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell walks a WIDTH-bit add LSB first,
// one bit per enabled cycle. Outputs come straight from registers.
//
// Handshake: start is a request sampled only on edges with ena=1 while not busy
// (IDLE or DONE); an accepted start clears done, and done then rises exactly
// WIDTH enabled edges later and holds sum/cout until the next accepted start.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output state_t           o_dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_last;

  fa_cell u_fa (
    .a  (r_sh_a[0]),
    .b  (r_sh_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_accept = ena && start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_count == CNT_W'(WIDTH - 1));

  always_comb begin
    w_next_state = r_state;
    if (ena) begin
      case (r_state)
        IDLE, DONE: if (start)  w_next_state = RUN;
        RUN:        if (w_last) w_next_state = DONE;
        default:                w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (ena) begin
      if (w_accept) begin
        // sum/cout are left alone here; the shift below overwrites them bit by bit
        r_sh_a  <= op_a;
        r_sh_b  <= op_b;
        r_carry <= cin;
        r_count <= '0;
      end else if (r_state == RUN) begin
        r_sum   <= {w_s, r_sum[WIDTH-1:1]};
        r_sh_a  <= {1'b0, r_sh_a[WIDTH-1:1]};
        r_sh_b  <= {1'b0, r_sh_b[WIDTH-1:1]};
        r_carry <= w_co;
        r_count <= r_count + 1'b1;
        if (w_last) r_cout <= w_co;
      end
    end
  end

  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed WIDTH=8 cases plus a random WIDTH=4 sweep,
// both checked every cycle against an arithmetic model of the add.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int WV [2] = '{8, 4};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_v [2];
  logic        ena_v   [2];
  logic        start_v [2];
  logic        cin_v   [2];
  logic [15:0] a_v     [2];
  logic [15:0] b_v     [2];

  logic       busy0, done0, cout0;
  logic [7:0] sum0;
  state_t     st0;
  logic       busy1, done1, cout1;
  logic [3:0] sum1;
  state_t     st1;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n_v[0]), .ena(ena_v[0]), .start(start_v[0]),
    .op_a(a_v[0][7:0]), .op_b(b_v[0][7:0]), .cin(cin_v[0]),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .o_dbg_state(st0)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n_v[1]), .ena(ena_v[1]), .start(start_v[1]),
    .op_a(a_v[1][3:0]), .op_b(b_v[1][3:0]), .cin(cin_v[1]),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .o_dbg_state(st1)
  );

  function automatic logic [31:0] f_sum(int i);
    return (i == 0) ? 32'(sum0) : 32'(sum1);
  endfunction
  function automatic logic f_busy(int i);
    return (i == 0) ? busy0 : busy1;
  endfunction
  function automatic logic f_done(int i);
    return (i == 0) ? done0 : done1;
  endfunction
  function automatic logic f_cout(int i);
    return (i == 0) ? cout0 : cout1;
  endfunction
  function automatic logic [31:0] f_state(int i);
    return (i == 0) ? 32'(st0) : 32'(st1);
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The result is plain a+b+cin; during the add, the sum register shows the old
  // value shifted right by k with the low k result bits sitting on top.
  logic        m_busy [2];
  logic        m_done [2];
  logic        m_cout [2];
  logic [31:0] m_sum  [2];
  logic [31:0] m_old  [2];
  logic [31:0] m_res  [2];
  int          m_k    [2];
  bit          chk_on = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int w;
      logic [31:0] mk;
      w  = WV[i];
      mk = (32'd1 << w) - 32'd1;
      if (!rst_n_v[i]) begin
        m_busy[i] = 1'b0; m_done[i] = 1'b0; m_cout[i] = 1'b0;
        m_sum[i]  = '0;   m_k[i]    = 0;
      end else if (ena_v[i]) begin
        if (m_busy[i]) begin
          m_k[i]++;
          m_sum[i] = ((m_old[i] >> m_k[i]) |
                      ((m_res[i] & ((32'd1 << m_k[i]) - 32'd1)) << (w - m_k[i]))) & mk;
          if (m_k[i] == w) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
            m_cout[i] = m_res[i][w];
          end
        end else if (start_v[i]) begin
          m_res[i]  = (32'(a_v[i]) & mk) + (32'(b_v[i]) & mk) + 32'(cin_v[i]);
          m_old[i]  = m_sum[i];
          m_k[i]    = 0;
          m_busy[i] = 1'b1;
          m_done[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        logic [31:0] exp_st;
        exp_st = m_busy[i] ? 32'(RUN) : (m_done[i] ? 32'(DONE) : 32'(IDLE));
        chk($sformatf("busy[w%0d]", WV[i]), 32'(f_busy(i)), 32'(m_busy[i]));
        chk($sformatf("done[w%0d]", WV[i]), 32'(f_done(i)), 32'(m_done[i]));
        chk($sformatf("sum[w%0d]",  WV[i]), f_sum(i), m_sum[i]);
        chk($sformatf("cout[w%0d]", WV[i]), 32'(f_cout(i)), 32'(m_cout[i]));
        chk($sformatf("state[w%0d]", WV[i]), f_state(i), exp_st);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called right after a negedge. Returns total edges and enabled edges from the
  // accepting edge until done is seen.
  task automatic run_add(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input int stall_at, input int stall_len,
                         input bit glitch, input bit rnd,
                         output int cyc, output int en_cnt);
    logic en_now;
    ena_v[i] = 1'b1; start_v[i] = 1'b1; a_v[i] = a; b_v[i] = b; cin_v[i] = c;
    @(negedge clk);
    start_v[i] = 1'b0;
    a_v[i] = 16'($urandom); b_v[i] = 16'($urandom); cin_v[i] = 1'($urandom);
    cyc = 0; en_cnt = 0;
    while (!f_done(i) && cyc < 200) begin
      if (rnd) begin
        en_now     = ($urandom_range(0, 3) != 0);
        start_v[i] = ($urandom_range(0, 4) == 0);
        a_v[i] = 16'($urandom); b_v[i] = 16'($urandom);
      end else begin
        en_now     = !(cyc >= stall_at && cyc < stall_at + stall_len);
        start_v[i] = glitch && (cyc == 2);
        if (glitch && cyc == 2) begin a_v[i] = 16'h0033; b_v[i] = 16'h0077; end
      end
      ena_v[i] = en_now;
      @(negedge clk);
      cyc++;
      if (en_now) en_cnt++;
    end
    if (cyc >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL timeout[w%0d]: done not seen after %0d cycles, required within %0d",
               WV[i], cyc, WV[i]);
    end
    start_v[i] = 1'b0; ena_v[i] = 1'b1;
  endtask

  task automatic chk_result(input string name, input int i,
                            input logic [31:0] es, input logic ec);
    chk({name, "_sum"},  f_sum(i), es);
    chk({name, "_cout"}, 32'(f_cout(i)), 32'(ec));
    exp_q.push_back(es);
  endtask

  // ---------------- stimulus ----------------
  int cyc, en_cnt;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n_v[i] = 1'b0; ena_v[i] = 1'b0; start_v[i] = 1'b0;
      cin_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_sum",  32'(sum0),  32'd0);
    chk("rst_cout", 32'(cout0), 32'd0);
    rst_n_v[0] = 1'b1; rst_n_v[1] = 1'b1;
    ena_v[0] = 1'b1; ena_v[1] = 1'b1;
    @(negedge clk);

    // basic add with latency and hold
    run_add(0, 16'h5A, 16'h33, 1'b0, -1, 0, 1'b0, 1'b0, cyc, en_cnt);
    chk("lat_5A_33", 32'(cyc), 32'd8);
    chk("model_5A_33", m_sum[0], 32'h8D);
    chk_result("add_5A_33", 0, 32'h8D, 1'b0);
    repeat (3) @(negedge clk);
    chk_result("hold_5A_33", 0, 32'h8D, 1'b0);

    // overflow paths
    run_add(0, 16'hFF, 16'h01, 1'b0, -1, 0, 1'b0, 1'b0, cyc, en_cnt);
    chk_result("ff_01", 0, 32'h00, 1'b1);
    run_add(0, 16'hFF, 16'h00, 1'b1, -1, 0, 1'b0, 1'b0, cyc, en_cnt);
    chk_result("ff_00_c1", 0, 32'h00, 1'b1);
    run_add(0, 16'h00, 16'h00, 1'b0, -1, 0, 1'b0, 1'b0, cyc, en_cnt);
    chk_result("zero", 0, 32'h00, 1'b0);

    // stall for 3 cycles plus an ignored start during RUN
    run_add(0, 16'h0F, 16'hF1, 1'b0, 3, 3, 1'b1, 1'b0, cyc, en_cnt);
    chk("lat_stall", 32'(cyc), 32'd11);
    chk("en_stall", 32'(en_cnt), 32'd8);
    chk_result("stall_0F_F1", 0, 32'h00, 1'b1);

    // back-to-back start from DONE
    ena_v[0] = 1'b1; start_v[0] = 1'b1; a_v[0] = 16'h80; b_v[0] = 16'h80; cin_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("b2b_done_drop", 32'(done0), 32'd0);
    cyc = 0;
    while (!done0 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("lat_b2b", 32'(cyc), 32'd8);
    chk_result("b2b_80_80", 0, 32'h00, 1'b1);

    // reset at bit 4
    ena_v[0] = 1'b1; start_v[0] = 1'b1; a_v[0] = 16'hAB; b_v[0] = 16'hCD; cin_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n_v[0] = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_done", 32'(done0), 32'd0);
    chk("midrst_sum",  32'(sum0),  32'd0);
    chk("midrst_cout", 32'(cout0), 32'd0);
    rst_n_v[0] = 1'b1;
    @(negedge clk);
    run_add(0, 16'h12, 16'h34, 1'b0, -1, 0, 1'b0, 1'b0, cyc, en_cnt);
    chk_result("after_rst", 0, 32'h46, 1'b0);

    // WIDTH=4 random sweep
    for (int n = 0; n < 200; n++) begin
      logic [15:0] ra, rb;
      logic        rc;
      logic [31:0] tot;
      ra = 16'($urandom_range(0, 15));
      rb = 16'($urandom_range(0, 15));
      rc = 1'($urandom);
      tot = 32'(ra) + 32'(rb) + 32'(rc);
      run_add(1, ra, rb, rc, -1, 0, 1'b0, 1'b1, cyc, en_cnt);
      chk("w4_lat", 32'(en_cnt), 32'd4);
      chk_result("w4_add", 1, tot & 32'hF, tot[4]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
